// File: rtl/mm_feeder_if.sv
// mm_feeder_if: groups the operand-RAM read port and the MM input stream
// of the matrix feeder.
//   mem_rd / mem_addr / mem_rdata : synchronous RAM read (data one cycle after mem_rd)
//   busy                          : MM stall, no transfer on an edge where it is high
//   in_valid / in_data            : element presented to MM
//   col_end / row_end             : last element of row / of matrix
// master = feeder side, slave = RAM + MM side.
interface mm_feeder_if #(
  parameter int ADDR_W = 14
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              col_end;
  logic              row_end;

  modport master (
    output mem_rd, mem_addr, in_valid, in_data, col_end, row_end,
    input  mem_rdata, busy
  );

  modport slave (
    input  mem_rd, mem_addr, in_valid, in_data, col_end, row_end,
    output mem_rdata, busy
  );
endinterface

// File: rtl/mm_feeder.sv
// mm_feeder: reads two row-major 8-bit matrices (matrix 2 stored directly
// after matrix 1) from a synchronous operand RAM and streams them element by
// element into the MM core, honouring MM back-pressure.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous reset, active low
//   i_start      request pulse, sampled only while idle
//   i_m1_rows/i_m1_cols/i_m2_rows/i_m2_cols  matrix shapes, sampled with i_start
//   i_base_addr  address of matrix 1 element (0,0), sampled with i_start
//   o_ready      high while idle
//   o_done       one-cycle pulse after the final transfer
//   o_cfg_err    one-cycle pulse after a start carrying a zero dimension
//   bus          RAM read port and MM stream (mm_feeder_if.master)
module mm_feeder #(
  parameter int ADDR_W = 14,
  parameter int DIM_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_m1_rows,
  input  logic [DIM_W-1:0]  i_m1_cols,
  input  logic [DIM_W-1:0]  i_m2_rows,
  input  logic [DIM_W-1:0]  i_m2_cols,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_cfg_err,
  mm_feeder_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIM_W-1:0]  r_m1_rows, r_m1_cols, r_m2_rows, r_m2_cols;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_k;      // linear element index across both matrices
  logic              r_mat;    // 0 = matrix 1, 1 = matrix 2
  logic [DIM_W-1:0]  r_r;
  logic [DIM_W-1:0]  r_c;
  logic              r_done;
  logic              r_cfg_err;

  logic [DIM_W-1:0]  w_rows;
  logic [DIM_W-1:0]  w_cols;
  logic              w_last_c;
  logic              w_last_r;
  logic              w_in_valid;
  logic              w_xfer;
  logic              w_final;
  logic              w_dims_ok;
  logic              w_accept;
  logic              w_mem_rd;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_rows     = r_mat ? r_m2_rows : r_m1_rows;
  assign w_cols     = r_mat ? r_m2_cols : r_m1_cols;
  assign w_last_c   = (r_c == (w_cols - DIM_W'(1)));
  assign w_last_r   = (r_r == (w_rows - DIM_W'(1)));
  assign w_in_valid = (r_state == ST_SEND);
  assign w_xfer     = w_in_valid & ~bus.busy;
  assign w_final    = r_mat & w_last_r & w_last_c;
  assign w_dims_ok  = (i_m1_rows != '0) & (i_m1_cols != '0) &
                      (i_m2_rows != '0) & (i_m2_cols != '0);
  assign w_accept   = (r_state == ST_IDLE) & i_start & w_dims_ok;

  // Next-state logic and RAM read request. The next read is issued in the
  // same cycle as a transfer so the stream runs at one element per cycle;
  // during a stall no read is issued and the RAM keeps presenting its data.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_rd    = 1'b0;
    w_mem_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        w_mem_rd    = 1'b1;
        w_mem_addr  = r_base + r_k;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (w_final) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_mem_rd    = 1'b1;
            w_mem_addr  = r_base + r_k + ADDR_W'(1);
            w_state_nxt = ST_SEND;
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and status pulses.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_xfer & w_final;
      r_cfg_err <= (r_state == ST_IDLE) & i_start & ~w_dims_ok;
    end
  end

  // Shape/base capture and element counters (column, row, matrix, linear).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_m1_rows <= '0;
      r_m1_cols <= '0;
      r_m2_rows <= '0;
      r_m2_cols <= '0;
      r_base    <= '0;
      r_k       <= '0;
      r_mat     <= 1'b0;
      r_r       <= '0;
      r_c       <= '0;
    end else if (w_accept) begin
      r_m1_rows <= i_m1_rows;
      r_m1_cols <= i_m1_cols;
      r_m2_rows <= i_m2_rows;
      r_m2_cols <= i_m2_cols;
      r_base    <= i_base_addr;
      r_k       <= '0;
      r_mat     <= 1'b0;
      r_r       <= '0;
      r_c       <= '0;
    end else if (w_xfer && !w_final) begin
      r_k <= r_k + ADDR_W'(1);
      if (w_last_c) begin
        r_c <= '0;
        if (w_last_r) begin
          // end of matrix 1: continue with matrix 2, k keeps counting
          r_r   <= '0;
          r_mat <= 1'b1;
        end else begin
          r_r <= r_r + DIM_W'(1);
        end
      end else begin
        r_c <= r_c + DIM_W'(1);
      end
    end
  end

  assign bus.mem_rd   = w_mem_rd;
  assign bus.mem_addr = w_mem_addr;
  assign bus.in_valid = w_in_valid;
  assign bus.in_data  = w_in_valid ? bus.mem_rdata : 8'd0;
  assign bus.col_end  = w_in_valid & w_last_c;
  assign bus.row_end  = w_in_valid & w_last_r & w_last_c;
  assign o_ready      = (r_state == ST_IDLE);
  assign o_done       = r_done;
  assign o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_mm_feeder.sv
// tb_mm_feeder: directed scoreboard bench for mm_feeder. The stimulus side
// pushes the hand-derived element stream (data, col_end, row_end) and RAM
// address sequence into queues; a monitor pops and compares on every
// transfer and every RAM read. RAM model: ram[a] = (a + 1) mod 256.
module tb_mm_feeder;

  typedef struct packed {
    logic [7:0] data;
    logic       col;
    logic       row;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  m1_rows, m1_cols, m2_rows, m2_cols;
  logic [13:0] base_addr;
  logic        o_ready, o_done, o_cfg_err;

  logic [7:0]  ram [0:16383];
  exp_t        exp_q[$];
  logic [13:0] addr_q[$];
  int          n_checks;
  int          n_fail;
  bit          done_pending;
  bit          cfg_test;

  mm_feeder_if #(.ADDR_W(14)) bus ();

  mm_feeder #(.ADDR_W(14), .DIM_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_start     (start),
    .i_m1_rows   (m1_rows),
    .i_m1_cols   (m1_cols),
    .i_m2_rows   (m2_rows),
    .i_m2_cols   (m2_cols),
    .i_base_addr (base_addr),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous operand RAM; output holds while mem_rd is low.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream: element i lives at base+i (mod 2^14), value = addr+1.
  task automatic push_stream(input int n, input logic [13:0] base,
                             input logic [15:0] cmask, input logic [15:0] rmask);
    for (int i = 0; i < n; i++) begin
      exp_t        e;
      logic [13:0] a;
      a      = base + 14'(i);
      e.data = 8'(a) + 8'd1;
      e.col  = cmask[i];
      e.row  = rmask[i];
      e.last = (i == n - 1);
      exp_q.push_back(e);
      addr_q.push_back(a);
    end
  endtask

  // Issues start (caller sits just after a negedge), drives busy stalls and
  // an optional ignored start mid-stream, and waits for done with a bound.
  task automatic run_stream(input logic [3:0] ar, input logic [3:0] ac,
                            input logic [3:0] br, input logic [3:0] bc,
                            input logic [13:0] base, input int n,
                            input logic [15:0] cmask, input logic [15:0] rmask,
                            input int stall_idx, input int stall_n, input bit junk);
    int cyc, tcount, vcyc, left;
    bit seen;
    push_stream(n, base, cmask, rmask);
    m1_rows = ar; m1_cols = ac; m2_rows = br; m2_cols = bc;
    base_addr = base;
    start = 1'b1;
    cyc = 0; tcount = 0; vcyc = 0; left = stall_n; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_done) begin
        seen     = 1'b1;
        start    = 1'b0;
        bus.busy = 1'b0;
      end else begin
        if (junk && bus.in_valid && tcount == 1) begin
          start = 1'b1;
          m1_rows = 4'd1; m1_cols = 4'd1; m2_rows = 4'd1; m2_cols = 4'd1;
          base_addr = 14'h0100;
        end else begin
          start = 1'b0;
        end
        if (bus.in_valid && tcount == stall_idx && left > 0) begin
          bus.busy = 1'b1;
          left--;
        end else begin
          bus.busy = 1'b0;
        end
        if (bus.in_valid) begin
          vcyc++;
          if (!bus.busy) tcount++;
        end
      end
    end
    check("done_seen", seen, 1'b1);
    check("valid_cycles", vcyc, n + stall_n);
    check("ready_with_done", o_ready, 1'b1);
    check("stream_drained", exp_q.size(), 0);
  endtask

  // Monitor: compares presented elements, stall behaviour, reads and pulses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("done_pulse", o_done, done_pending);
        done_pending = 1'b0;
        if (!cfg_test) check("cfg_err_quiet", o_cfg_err, 1'b0);
        if (bus.in_valid) begin
          check("element_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            check("in_data", bus.in_data, exp_q[0].data);
            check("col_end", bus.col_end, exp_q[0].col);
            check("row_end", bus.row_end, exp_q[0].row);
            if (bus.busy) begin
              check("stall_no_read", bus.mem_rd, 1'b0);
            end else begin
              done_pending = exp_q[0].last;
              void'(exp_q.pop_front());
            end
          end
        end else begin
          check("idle_flags", {bus.in_data, bus.col_end, bus.row_end}, 10'd0);
        end
        if (bus.mem_rd) begin
          check("read_expected", addr_q.size() > 0, 1'b1);
          if (addr_q.size() > 0) begin
            check("mem_addr", bus.mem_addr, addr_q[0]);
            void'(addr_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int  tcount, cyc;
    bit  hit;
    n_checks = 0; n_fail = 0; done_pending = 1'b0; cfg_test = 1'b0;
    for (int i = 0; i < 16384; i++) ram[i] = 8'(i + 1);
    rst_n = 1'b0; start = 1'b0; bus.busy = 1'b0;
    m1_rows = 4'd0; m1_cols = 4'd0; m2_rows = 4'd0; m2_cols = 4'd0;
    base_addr = 14'd0;
    #12;
    check("rst_ready", o_ready, 1'b1);
    check("rst_outputs", {bus.mem_rd, bus.mem_addr, bus.in_valid, bus.in_data,
                          bus.col_end, bus.row_end, o_done, o_cfg_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 2x3 then 3x2, base 0: col_end at 2,5,7,9,11; row_end at 5,11
    run_stream(4'd2, 4'd3, 4'd3, 4'd2, 14'd0, 12, 16'h0AA4, 16'h0820, -1, 0, 1'b0);
    @(negedge clk);
    // same stream, busy for 3 cycles while element 4 (value 5) is presented
    run_stream(4'd2, 4'd3, 4'd3, 4'd2, 14'd0, 12, 16'h0AA4, 16'h0820, 4, 3, 1'b0);
    @(negedge clk);
    // 1x1 then 1x1, re-started in the done cycle
    run_stream(4'd1, 4'd1, 4'd1, 4'd1, 14'd0, 2, 16'h0003, 16'h0003, -1, 0, 1'b0);
    run_stream(4'd1, 4'd1, 4'd1, 4'd1, 14'd0, 2, 16'h0003, 16'h0003, -1, 0, 1'b0);
    @(negedge clk);
    // 2x3 then 2x2: col_end at 2,5,7,9; row_end at 5,9
    run_stream(4'd2, 4'd3, 4'd2, 4'd2, 14'd0, 10, 16'h02A4, 16'h0220, -1, 0, 1'b0);

    // zero dimension: single cfg_err pulse, no read, ready stays high
    @(negedge clk);
    cfg_test = 1'b1;
    m1_rows = 4'd2; m1_cols = 4'd3; m2_rows = 4'd3; m2_cols = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", o_cfg_err, 1'b1);
    check("cfg_ready", o_ready, 1'b1);
    check("cfg_no_read", bus.mem_rd, 1'b0);
    @(negedge clk);
    check("cfg_err_clear", o_cfg_err, 1'b0);
    check("cfg_ready2", o_ready, 1'b1);
    check("cfg_no_read2", bus.mem_rd, 1'b0);
    @(negedge clk);
    cfg_test = 1'b0;

    // address wrap from 0x3FFE, with an ignored start mid-stream
    run_stream(4'd2, 4'd2, 4'd2, 4'd2, 14'h3FFE, 8, 16'h00AA, 16'h0088, -1, 0, 1'b1);

    // reset while element 3 is presented
    @(negedge clk);
    push_stream(8, 14'h3FFE, 16'h00AA, 16'h0088);
    m1_rows = 4'd2; m1_cols = 4'd2; m2_rows = 4'd2; m2_cols = 4'd2;
    base_addr = 14'h3FFE;
    start = 1'b1;
    tcount = 0; cyc = 0; hit = 1'b0;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (bus.in_valid) begin
        if (tcount == 3) hit = 1'b1;
        else tcount++;
      end
    end
    check("reset_point_reached", hit, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", o_ready, 1'b1);
    check("async_rst_outputs", {bus.mem_rd, bus.mem_addr, bus.in_valid, bus.in_data,
                                bus.col_end, bus.row_end, o_done, o_cfg_err}, 32'd0);
    exp_q.delete();
    addr_q.delete();
    done_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_resume_valid", bus.in_valid, 1'b0);
      check("no_resume_read", bus.mem_rd, 1'b0);
      check("no_resume_ready", o_ready, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_feeder.md
# mm_feeder

Stream source for the MM matrix-multiply core: reads two row-major matrices from a synchronous 8-bit operand RAM and presents them element by element on MM's input side (`in_data`, `col_end`, `row_end`), obeying MM's `busy` back-pressure. It replaces the bench-driven stimulus path so the MM subsystem can run from memory-resident operands. Matrix 2 is stored immediately after matrix 1. The feeder does not check dimension legality; that is MM's job.

## Interface

- `ADDR_W`, 14, operand RAM address width
- `DIM_W`, 4, dimension field width (dimensions 1..15)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `m1_rows`, `m1_cols`, `m2_rows`, `m2_cols`  in  DIM_W each  matrix shapes, sampled with `start`
- `base_addr`  in  ADDR_W  address of matrix 1 element (0,0), sampled with `start`
- `mem_rd`  out  1  RAM read enable
- `mem_addr`  out  ADDR_W  RAM read address
- `mem_rdata`  in  8  RAM data; valid the cycle after `mem_rd`; RAM holds its output while `mem_rd`=0
- `busy`  in  1  MM stall; no transfer on an edge where it is high
- `in_valid`  out  1  element present on `in_data`
- `in_data`  out  8  `in_valid ? mem_rdata : 0`
- `col_end`  out  1  current element is the last of its row
- `row_end`  out  1  current element is the last of its matrix
- `ready`  out  1  high in IDLE
- `done`  out  1  one-cycle pulse after the final transfer
- `cfg_err`  out  1  one-cycle pulse: `start` with a zero dimension

## Operation

- States: IDLE, RD, SEND.
- IDLE → RD: `start`=1 and all dims nonzero. Latch shapes and base. Clear `k`, `mat`, `r`, `c`.
- IDLE with `start`=1 and any dim 0: `cfg_err`=1 next cycle, stay IDLE.
- `start` outside IDLE is ignored.
- RD: `mem_rd`=1, `mem_addr`=`base+k`, then go to SEND.
- SEND: `in_valid`=1.
  - Transfer = `in_valid & !busy` at the rising edge.
  - On a transfer that is not the last element: `mem_rd`=1 in the same cycle with `mem_addr`=`base+k+1`. Advance counters. Stay in SEND.
  - While `busy`=1: `mem_rd`=0; `in_data` and the flags hold.
- Counters:
  - `c` increments and wraps at cols-1, then `r` increments.
  - At the end of matrix 1 (rows·cols elements), `mat` goes 0→1 and `r`/`c` clear.
  - `k` is the linear element index and is never reset between matrices.
- `col_end` = `in_valid & (c == cols(mat)-1)`.
- `row_end` = `in_valid & (r == rows(mat)-1) & (c == cols(mat)-1)`.
- Last element = last element of matrix 2. Its transfer → IDLE and `done`=1 for the next cycle. `in_valid`, `col_end`, `row_end` are 0 from then on.
- Address arithmetic is modulo 2^ADDR_W; `base+k` wraps past all-ones to 0.
- Reset (any time, including mid-stream) → IDLE.
  - Outputs: `mem_rd`=0, `mem_addr`=0, `in_valid`=0, `in_data`=0, `col_end`=0, `row_end`=0, `done`=0, `cfg_err`=0, `ready`=1.
  - No partial stream resumes after reset.

## Timing

- `start` sampled at edge E0 → `mem_rd`=1 in cycle E0..E1 → `in_valid`=1 from E1.
- Latency from `start` to first element: 2 cycles.
- Throughput: 1 element/cycle while `busy`=0. Stream length = m1_rows·m1_cols + m2_rows·m2_cols cycles plus stall cycles.
- `done` rises at the edge of the final transfer and lasts one cycle. `ready` rises in the same cycle.
- A new `start` is accepted in the same cycle as `done`.

## Test plan

- 2x3 then 3x2, base 0, RAM[i]=i+1, busy=0:
  - 12 consecutive `in_valid` cycles with `in_data` 1..12.
  - `col_end` at elements 2, 5, 7, 9, 11; `row_end` at 5 and 11.
  - `done` one cycle after element 11.
- Same stream with `busy` high for 3 cycles while element 4 (value 5) is presented: value 5 is held, `mem_rd`=0 during the stall, no element duplicated or skipped, 15 cycles total.
- 1x1 then 1x1: two elements, each with `col_end`=`row_end`=1. `done` pulses. Immediate re-`start` is accepted.
- Shape mismatch 2x3 then 2x2: all 10 elements stream normally. `row_end` at elements 5 and 9.
- `m2_cols`=0 with `start`: one `cfg_err` pulse, `ready` stays 1, `mem_rd` never asserts.
- base 0x3FFE, 2x2 then 2x2: addresses 3FFE, 3FFF, 0000, … 0005. Reset asserted at element 3 → all outputs 0 and `ready`=1 asynchronously. `start` pulses during streaming are ignored.
